dc_word_fifo: RTL and testbench

Dual-clock word FIFO that carries data between the 100 MHz fabric clock domain and the FTDI FT600/601 USB clock domain. The USB bridge uses two instances: an IN buffer (USB to fabric) and an OUT buffer (fabric to USB). Writes are clocked by `iCLK`, reads by `rdclk`, and `empty`/`full` are each reported in their own domain. The PLL that generates the 100 MHz clock is vendor IP and sits outside this block.

---
 rtl/dc_word_fifo_pkg.sv | 9 +
 rtl/dc_word_fifo_gray_sync.sv | 27 ++
 rtl/dc_word_fifo.sv | 116 +++++++++++
 tb/tb_dc_word_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dc_word_fifo_pkg.sv
// Shared sizing for the dual-clock word FIFO used by the USB bridge.
// Default geometry holds exactly one 1024-byte USB packet of 32-bit words.
package dc_word_fifo_pkg;

  localparam int DEF_D_BIT    = 32;
  localparam int DEF_ADDR_BIT = 8;
  localparam int BUF_SIZE     = 1 << DEF_ADDR_BIT;

endpackage

// File: rtl/dc_word_fifo_gray_sync.sv
// Two-flop synchronizer for a Gray-coded pointer, cleared asynchronously.
// Only one bit of a Gray pointer changes per step, so a multi-bit crossing is safe.
module gray_sync #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/dc_word_fifo.sv
// Dual-clock word FIFO: writes on iCLK, reads on rdclk, Gray pointers cross domains.
// Flags are registered and conservative: they may clear late but never assert late.
module dc_word_fifo
  import dc_word_fifo_pkg::*;
#(
  parameter int D_BIT    = DEF_D_BIT,
  parameter int ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic             iCLK,
  input  logic             rdclk,
  input  logic             reset,
  input  logic             wrreq,
  input  logic [D_BIT-1:0] data,
  output logic             wrfull,
  input  logic             rdreq,
  output logic [D_BIT-1:0] q,
  output logic             rdempty
);

  localparam int PW    = ADDR_BIT + 1;
  localparam int DEPTH = 1 << ADDR_BIT;

  logic [D_BIT-1:0] mem [DEPTH];

  // Per-domain reset: asserts immediately, releases on the local clock.
  logic [1:0] wrst_q;
  logic [1:0] rrst_q;
  logic       wrst;
  logic       rrst;

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) wrst_q <= 2'b11;
    else       wrst_q <= {wrst_q[0], 1'b0};
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) rrst_q <= 2'b11;
    else       rrst_q <= {rrst_q[0], 1'b0};
  end

  assign wrst = wrst_q[1];
  assign rrst = rrst_q[1];

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          wfull_q, wfull_d;
  logic [PW-1:0] wq2_rgray;
  logic          wr_en;

  assign wr_en   = wrreq & ~wfull_q;
  assign wbin_d  = wbin_q + PW'(wr_en);
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;
  // Full when the write side is exactly one lap ahead of the read side.
  assign wfull_d = (wgray_d == {~wq2_rgray[PW-1:PW-2], wq2_rgray[PW-3:0]});

  always_ff @(posedge iCLK or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (wr_en) mem[wbin_q[ADDR_BIT-1:0]] <= data;
  end

  logic [PW-1:0]    rbin_q, rbin_d;
  logic [PW-1:0]    rgray_q, rgray_d;
  logic             rempty_q, rempty_d;
  logic [PW-1:0]    rq2_wgray;
  logic [D_BIT-1:0] q_q;
  logic             rd_en;

  assign rd_en    = rdreq & ~rempty_q;
  assign rbin_d   = rbin_q + PW'(rd_en);
  assign rgray_d  = (rbin_d >> 1) ^ rbin_d;
  assign rempty_d = (rgray_d == rq2_wgray);

  always_ff @(posedge rdclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      q_q      <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
      if (rd_en) q_q <= mem[rbin_q[ADDR_BIT-1:0]];
    end
  end

  gray_sync #(.W(PW)) u_sync_w2r (
    .clk_i (rdclk),
    .clr_i (rrst),
    .d_i   (wgray_q),
    .q_o   (rq2_wgray)
  );

  gray_sync #(.W(PW)) u_sync_r2w (
    .clk_i (iCLK),
    .clr_i (wrst),
    .d_i   (rgray_q),
    .q_o   (wq2_rgray)
  );

  assign wrfull  = wfull_q;
  assign rdempty = rempty_q;
  assign q       = q_q;

endmodule

// File: tb/tb_dc_word_fifo.sv
// Directed bench for dc_word_fifo: 100 MHz write clock, 50 MHz read clock.
module tb_dc_word_fifo;

  logic        iCLK = 1'b0;
  logic        rd_raw = 1'b0;
  logic        rd_inv = 1'b0;
  logic        rdclk;
  logic        reset = 1'b1;
  logic        wrreq = 1'b0;
  logic [31:0] data = '0;
  logic        wrfull;
  logic        rdreq = 1'b0;
  logic [31:0] q;
  logic        rdempty;

  int n_tests = 0;
  int n_fail  = 0;
  int count   = 0;
  int sent    = 0;
  int rcvd    = 0;

  always #5 iCLK = ~iCLK;
  initial begin
    #3;
    forever #10 rd_raw = ~rd_raw;
  end
  assign rdclk = rd_raw ^ rd_inv;

  dc_word_fifo dut (
    .iCLK    (iCLK),
    .rdclk   (rdclk),
    .reset   (reset),
    .wrreq   (wrreq),
    .data    (data),
    .wrfull  (wrfull),
    .rdreq   (rdreq),
    .q       (q),
    .rdempty (rdempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d, input bit forced);
    int n;
    n = 0;
    @(negedge iCLK);
    while (!forced && wrfull && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    if (!forced && wrfull) check("wr_wait", wrfull, 1'b0);
    wrreq = 1'b1;
    data  = d;
    @(posedge iCLK);
    #1;
    wrreq = 1'b0;
  endtask

  task automatic read_word(output logic [31:0] d);
    int n;
    n = 0;
    @(negedge rdclk);
    while (rdempty && n < 100) begin
      @(negedge rdclk);
      n++;
    end
    if (rdempty) check("rd_wait", rdempty, 1'b0);
    rdreq = 1'b1;
    @(posedge rdclk);
    #1;
    rdreq = 1'b0;
    d = q;
  endtask

  initial begin
    logic [31:0] d;
    int seq;
    int n;

    // Reset then idle
    #53 reset = 1'b0;
    repeat (10) @(negedge iCLK);
    check("rst_rdempty", rdempty, 1'b1);
    check("rst_wrfull", wrfull, 1'b0);
    check("rst_q", q, 32'h0);
    repeat (3) begin
      @(negedge rdclk);
      rdreq = 1'b1;
      @(posedge rdclk);
      #1;
      rdreq = 1'b0;
    end
    check("idle_rd_q", q, 32'h0);
    check("idle_rd_empty", rdempty, 1'b1);

    // Single word
    write_word(32'h00010203, 1'b0);
    repeat (3) @(posedge rdclk);
    #1;
    check("single_empty_fall", rdempty, 1'b0);
    read_word(d);
    check("single_q", d, 32'h00010203);
    check("single_empty_back", rdempty, 1'b1);

    // Fill to 256, overflow attempt, drain
    repeat (5) @(negedge iCLK);
    for (int i = 0; i < 256; i++) begin
      write_word(i, 1'b0);
      if (i == 254) check("fill_255_not_full", wrfull, 1'b0);
      if (i == 255) check("fill_256_full", wrfull, 1'b1);
    end
    write_word(32'h0000DEAD, 1'b1);
    check("overflow_still_full", wrfull, 1'b1);
    read_word(d);
    check("fill_rd_0", d, 32'h0);
    repeat (3) @(posedge iCLK);
    #1;
    check("full_release_3clk", wrfull, 1'b0);
    n = 0;
    for (int i = 1; i < 256; i++) begin
      read_word(d);
      if (d !== i) n++;
      if (i == 255) check("fill_rd_255", d, 32'd255);
    end
    check("fill_order_errors", n, 0);
    check("fill_drained_empty", rdempty, 1'b1);
    repeat (8) @(posedge rdclk);
    #1;
    check("no_deadbeef_entry", rdempty, 1'b1);

    // Wrap-around with inverted read clock phase
    rd_inv = 1'b1;
    seq = 1000;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 200; i++) write_word(1000 + r * 200 + i, 1'b0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
        read_word(d);
        if (d !== seq) n++;
        seq++;
      end
      check("wrap_round_errors", n, 0);
      check("wrap_round_empty", rdempty, 1'b1);
    end

    // Concurrent random streaming against a word count
    count = 0;
    sent  = 0;
    rcvd  = 0;
    fork
      begin
        for (int it = 0; it < 20000 && sent < 300; it++) begin
          @(negedge iCLK);
          check("full_vs_count", (!wrfull && count >= 256), 1'b0);
          if (!wrfull && $urandom_range(0, 1) == 1) begin
            wrreq = 1'b1;
            data  = 5000 + sent;
          end
          @(posedge iCLK);
          #1;
          if (wrreq) begin
            sent++;
            count++;
          end
          wrreq = 1'b0;
        end
      end
      begin
        for (int it = 0; it < 20000 && rcvd < 300; it++) begin
          @(negedge rdclk);
          check("empty_vs_count", (!rdempty && count <= 0), 1'b0);
          if (!rdempty && $urandom_range(0, 2) != 0) rdreq = 1'b1;
          @(posedge rdclk);
          #1;
          if (rdreq) begin
            if (q !== 5000 + rcvd) check("stream_data", q, 5000 + rcvd);
            rcvd++;
            count--;
          end
          rdreq = 1'b0;
        end
      end
    join
    check("stream_sent", sent, 300);
    check("stream_rcvd", rcvd, 300);
    check("stream_final_empty", rdempty, 1'b1);

    // Reset mid-stream with 10 words queued
    for (int i = 0; i < 10; i++) write_word(6000 + i, 1'b0);
    n = 0;
    while (rdempty && n < 20) begin
      @(negedge rdclk);
      n++;
    end
    check("pre_reset_not_empty", rdempty, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_rdempty", rdempty, 1'b1);
    check("midrst_wrfull", wrfull, 1'b0);
    check("midrst_q", q, 32'h0);
    #30;
    @(negedge iCLK);
    reset = 1'b0;
    repeat (10) @(negedge iCLK);
    check("post_rst_empty", rdempty, 1'b1);
    write_word(32'h77770001, 1'b0);
    write_word(32'h77770002, 1'b0);
    read_word(d);
    check("post_rst_first", d, 32'h77770001);
    read_word(d);
    check("post_rst_second", d, 32'h77770002);
    check("post_rst_empty_end", rdempty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
